run_tally: RTL and testbench
============================

// Module: run_tally
// PURPOSE
//  Parametrised scoring engine. Accepts one play event per handshake, keeps base
//  occupancy and outs internally, and emits a one-cycle runs pulse with a 0..4 count.
//  Accumulates saturating scores for N_TEAMS batting teams in rotation.
//  Sits between the play-input decoder and the scoreboard display driver.
// PARAMETERS
//  N_TEAMS   2  number of teams batting in rotation (>=2)
//  SCORE_W   7  width of each team's score counter
//  MAX_OUTS  3  outs that retire the side (1..3)
// PORTS
//  clk          in   1                 single clock, rising edge
//  reset        in   1                 synchronous, active-high
//  ev_valid     in   1                 play event present
//  ev_code      in   3                 0 out,1 single,2 double,3 triple,4 HR,5 walk(opt),6-7 illegal
//  ev_ready     out  1                 engine can accept an event this cycle
//  bases        out  3                 {b3,b2,b1} occupancy
//  outs         out  2                 outs in current half-inning
//  bat_team     out  max(1,clog2(N_TEAMS))  team currently batting
//  runs_valid   out  1                 one-cycle pulse: runs scored by the last event
//  runs_count   out  3                 runs for that event (0..4); held between pulses
//  side_retired out  1                 one-cycle pulse on the MAX_OUTS-th out
//  illegal_ev   out  1                 one-cycle pulse: an illegal code was accepted
//  score_flat   out  N_TEAMS*SCORE_W   team t at [t*SCORE_W +: SCORE_W]
//  score_sat    out  N_TEAMS           sticky per-team saturation flag
// BEHAVIOUR
//  Reset: state=IDLE; bases=0, outs=0, bat_team=0, all scores=0, score_sat=0.
//   All pulses=0, runs_count=0, ev_ready=1. Reset wins over any in-flight event.
//  FSM: IDLE -> APPLY on accept (ev_valid&&ev_ready). APPLY -> IDLE after 1 cycle.
//   ev_ready=1 only in IDLE, so the engine sustains at most one event per 2 cycles.
//   ev_code is sampled only on the accept cycle.
//  Event accepted at edge t: bases, outs, score and pulses update together at edge t+1.
//   The pulses are high for exactly the cycle after edge t+1. Latency is 1.
//  Advancement from old {b3,b2,b1}:
//   single: runs=b3;          bases={b2,b1,1}
//   double: runs=b3+b2;       bases={b1,1,0}
//   triple: runs=b3+b2+b1;    bases=100
//   HR:     runs=b3+b2+b1+1;  bases=000
//   walk:   runs=b1&b2&b3;    bases={b3|(b1&b2), b2|b1, 1}
//  runs_valid pulses on every hit/walk, even when runs=0. runs_count is the
//   computed value. runs_valid is not asserted for out or illegal events.
//  Score: score[bat_team] += runs, clamped to 2^SCORE_W-1. Clamping sets score_sat[bat_team].
//   score_sat clears only on reset.
//  Out: outs+1. When outs+1==MAX_OUTS instead:
//   outs=0, bases=0, side_retired=1, bat_team=(bat_team+1) mod N_TEAMS (wraps N_TEAMS-1 -> 0).
//  Illegal code (6,7, or 5 when walks are compiled out): handshake completes,
//   state is unchanged, illegal_ev=1.
//  ev_valid held high through APPLY is not double-counted. It is re-accepted only
//   when IDLE raises ev_ready again.
// CONFIGURATION
//  RUN_TALLY_WALK_EN defined:   code 5 = walk with forced advancement as above.
//  RUN_TALLY_WALK_EN undefined: code 5 is illegal; the walk logic is not built.
// STRUCTURE
//  Shared package bb_pkg holds:
//   event-code constants EV_OUT..EV_WALK and base-index constants B1/B2/B3;
//   FSM state encodings ST_IDLE/ST_APPLY;
//   the runs-count width constant RUNS_W=3.
//  One combinational sub-module, base_advance: (bases, ev_code) -> (next_bases, runs, is_hit).
//   It contains the walk branch under RUN_TALLY_WALK_EN.
//  run_tally holds the FSM, outs/team counters, score array, saturation and pulses.
// TESTING
//  1 Reset, bases=111, HR -> runs_valid=1, runs_count=4, bases=000, score0=4 one cycle after accept.
//  2 Bases=011, double -> runs_count=1, bases=110. Then single -> runs_count=1, bases=101.
//  3 Three outs with bases=101 -> side_retired pulse on 3rd, outs=0, bases=0, bat_team=1.
//   With N_TEAMS=2, three more outs -> bat_team=0.
//  4 SCORE_W=3, score0=6, HR with bases=000 -> score0=7, score_sat[0]=1.
//   Next HR keeps score0=7.
//  5 ev_valid held high 6 cycles with singles -> exactly 3 accepts.
//   ev_ready pattern 1,0,1,0,1,0.
//  6 Code 5 with bases=111: WALK_EN build -> runs_count=1, bases=111.
//   Non-WALK_EN build -> illegal_ev=1, no state change.
//   In both builds, reset asserted in APPLY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/bb_pkg.sv
// Shared constants for the run_tally scoring engine: play-event codes,
// base indices within the {b3,b2,b1} occupancy vector, FSM states and the
// width of the per-event runs count.
package bb_pkg;

    localparam logic [2:0] EV_OUT    = 3'd0;
    localparam logic [2:0] EV_SINGLE = 3'd1;
    localparam logic [2:0] EV_DOUBLE = 3'd2;
    localparam logic [2:0] EV_TRIPLE = 3'd3;
    localparam logic [2:0] EV_HR     = 3'd4;
    localparam logic [2:0] EV_WALK   = 3'd5;

    localparam int B1 = 0;
    localparam int B2 = 1;
    localparam int B3 = 2;

    localparam int RUNS_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

endpackage

// File: rtl/run_tally_base_advance.sv
// base_advance: combinational runner advancement for one play event.
// Given the current {b3,b2,b1} occupancy and an event code it returns the new
// occupancy, the runs that crossed the plate and whether the event was a
// scoring play (hit or walk). Outs and illegal codes report is_hit=0 and
// leave the bases untouched; the caller decides what to do with them.
// Build option: RUN_TALLY_WALK_EN adds the forced-advancement walk on code 5;
// without it code 5 falls through to the default (not a scoring play).
module base_advance
    import bb_pkg::*;
(
    input  logic [2:0]        bases,
    input  logic [2:0]        ev_code,
    output logic [2:0]        next_bases,
    output logic [RUNS_W-1:0] runs,
    output logic              is_hit
);

    // Advance runners by the number of bases the batter reached.
    always_comb begin
        next_bases = bases;
        runs       = '0;
        is_hit     = 1'b0;
        case (ev_code)
            EV_SINGLE: begin
                is_hit     = 1'b1;
                runs       = RUNS_W'(bases[B3]);
                next_bases = {bases[B2], bases[B1], 1'b1};
            end
            EV_DOUBLE: begin
                is_hit     = 1'b1;
                runs       = RUNS_W'(bases[B3]) + RUNS_W'(bases[B2]);
                next_bases = {bases[B1], 2'b10};
            end
            EV_TRIPLE: begin
                is_hit     = 1'b1;
                runs       = RUNS_W'(bases[B3]) + RUNS_W'(bases[B2]) + RUNS_W'(bases[B1]);
                next_bases = 3'b100;
            end
            EV_HR: begin
                is_hit     = 1'b1;
                runs       = RUNS_W'(bases[B3]) + RUNS_W'(bases[B2]) + RUNS_W'(bases[B1])
                             + RUNS_W'(1);
                next_bases = 3'b000;
            end
`ifdef RUN_TALLY_WALK_EN
            EV_WALK: begin
                // Only runners forced by the batter move; a run scores only
                // when the bases were loaded.
                is_hit     = 1'b1;
                runs       = RUNS_W'(&bases);
                next_bases = {bases[B3] | (bases[B1] & bases[B2]), bases[B2] | bases[B1], 1'b1};
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/run_tally.sv
// run_tally: scoring engine. Accepts one play event per valid/ready handshake,
// applies it one cycle later, and keeps bases, outs, the batting team and a
// saturating score per team.
// Handshake: an event is accepted on a rising edge where ev_valid && ev_ready;
// ev_code is sampled only then. ev_ready is high only in IDLE, so a held
// ev_valid is accepted at most once per two cycles.
// Build option: RUN_TALLY_WALK_EN enables code 5 (walk); otherwise it is illegal.
// state_dbg exposes the FSM state (1 = APPLY) for checkers.
module run_tally
    import bb_pkg::*;
#(
    parameter int N_TEAMS  = 2,
    parameter int SCORE_W  = 7,
    parameter int MAX_OUTS = 3,
    localparam int BT_W    = ($clog2(N_TEAMS) > 1) ? $clog2(N_TEAMS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ev_valid,
    input  logic [2:0]                 ev_code,
    output logic                       ev_ready,
    output logic [2:0]                 bases,
    output logic [1:0]                 outs,
    output logic [BT_W-1:0]            bat_team,
    output logic                       runs_valid,
    output logic [2:0]                 runs_count,
    output logic                       side_retired,
    output logic                       illegal_ev,
    output logic [N_TEAMS*SCORE_W-1:0] score_flat,
    output logic [N_TEAMS-1:0]         score_sat,
    output logic                       state_dbg
);

    localparam int SUM_W = SCORE_W + RUNS_W;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((1 << SCORE_W) - 1);

    state_t              state_q, state_d;
    logic [2:0]          code_q;
    logic [2:0]          bases_q;
    logic [1:0]          outs_q;
    logic [BT_W-1:0]     team_q;
    logic [SCORE_W-1:0]  score_q [N_TEAMS];
    logic [N_TEAMS-1:0]  sat_q;
    logic                runs_valid_q, side_retired_q, illegal_q;
    logic [RUNS_W-1:0]   runs_count_q;

    logic [2:0]          adv_bases;
    logic [RUNS_W-1:0]   adv_runs;
    logic                adv_hit;
    logic                accept;
    logic                is_out;
    logic [1:0]          outs_inc;
    logic                retire;
    logic [BT_W-1:0]     team_next;
    logic [SUM_W-1:0]    score_sum;

    assign accept = ev_valid && ev_ready;

    base_advance u_adv (
        .bases      (bases_q),
        .ev_code    (code_q),
        .next_bases (adv_bases),
        .runs       (adv_runs),
        .is_hit     (adv_hit)
    );

    // Next-state and handshake: ready only while idle.
    always_comb begin
        state_d  = state_q;
        ev_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) state_d = ST_APPLY;
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Capture the event code on the accept edge; it is applied next cycle.
    always_ff @(posedge clk) begin
        if (reset)       code_q <= EV_OUT;
        else if (accept) code_q <= ev_code;
    end

    // Derived values for the event being applied.
    always_comb begin
        is_out    = (code_q == EV_OUT);
        outs_inc  = outs_q + 2'd1;
        retire    = is_out && (outs_inc == 2'(MAX_OUTS));
        team_next = (team_q == BT_W'(N_TEAMS - 1)) ? '0 : team_q + BT_W'(1);
        score_sum = SUM_W'(score_q[team_q]) + SUM_W'(adv_runs);
    end

    // Apply the captured event: bases, outs, team, score and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bases_q        <= '0;
            outs_q         <= '0;
            team_q         <= '0;
            sat_q          <= '0;
            runs_valid_q   <= 1'b0;
            runs_count_q   <= '0;
            side_retired_q <= 1'b0;
            illegal_q      <= 1'b0;
            for (int t = 0; t < N_TEAMS; t++) score_q[t] <= '0;
        end else begin
            runs_valid_q   <= 1'b0;
            side_retired_q <= 1'b0;
            illegal_q      <= 1'b0;
            if (state_q == ST_APPLY) begin
                if (adv_hit) begin
                    bases_q      <= adv_bases;
                    runs_valid_q <= 1'b1;
                    runs_count_q <= adv_runs;
                    // Reaching the ceiling marks the team as saturated.
                    if (score_sum >= SCORE_MAX) begin
                        score_q[team_q] <= SCORE_MAX[SCORE_W-1:0];
                        sat_q[team_q]   <= 1'b1;
                    end else begin
                        score_q[team_q] <= score_sum[SCORE_W-1:0];
                    end
                end else if (is_out) begin
                    if (retire) begin
                        outs_q         <= '0;
                        bases_q        <= '0;
                        team_q         <= team_next;
                        side_retired_q <= 1'b1;
                    end else begin
                        outs_q <= outs_inc;
                    end
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    // Flatten the score array onto the output bus.
    always_comb begin
        score_flat = '0;
        for (int t = 0; t < N_TEAMS; t++) score_flat[t*SCORE_W +: SCORE_W] = score_q[t];
    end

    assign bases        = bases_q;
    assign outs         = outs_q;
    assign bat_team     = team_q;
    assign runs_valid   = runs_valid_q;
    assign runs_count   = runs_count_q;
    assign side_retired = side_retired_q;
    assign illegal_ev   = illegal_q;
    assign score_sat    = sat_q;
    assign state_dbg    = (state_q == ST_APPLY);

endmodule

// File: tb/tb_run_tally.sv
// Testbench for run_tally: directed scenarios plus randomized events, checked
// by a scoreboard fed from a game-level reference model.
module tb_run_tally;

  localparam int N     = 2;
  localparam int SW    = 3;
  localparam int MOUTS = 3;
  localparam int BT_W  = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int EXP_W = 3 + 2 + BT_W + 1 + 3 + 1 + 1 + N*SW + N;
  localparam int SMAX  = (1 << SW) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ev_valid = 1'b0;
  logic [2:0]       ev_code = 3'd0;
  logic             ev_ready;
  logic [2:0]       bases;
  logic [1:0]       outs;
  logic [BT_W-1:0]  bat_team;
  logic             runs_valid;
  logic [2:0]       runs_count;
  logic             side_retired;
  logic             illegal_ev;
  logic [N*SW-1:0]  score_flat;
  logic [N-1:0]     score_sat;
  logic             state_dbg;

  run_tally #(.N_TEAMS(N), .SCORE_W(SW), .MAX_OUTS(MOUTS)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ready(ev_ready), .bases(bases), .outs(outs), .bat_team(bat_team),
    .runs_valid(runs_valid), .runs_count(runs_count), .side_retired(side_retired),
    .illegal_ev(illegal_ev), .score_flat(score_flat), .score_sat(score_sat),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [EXP_W-1:0] exp_q[$];

  // reference model: game state held as plain integers
  bit occ[4];
  int outs_m, team_m, last_runs;
  int score_m[N];
  bit sat_m[N];
  bit rv_m, sr_m, il_m;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] model_pack();
    logic [N*SW-1:0] sf;
    logic [N-1:0]    st;
    logic [2:0]      b;
    sf = '0;
    st = '0;
    for (int t = 0; t < N; t++) begin
      sf[t*SW +: SW] = SW'(score_m[t]);
      st[t] = sat_m[t];
    end
    b = {occ[3], occ[2], occ[1]};
    return {b, 2'(outs_m), BT_W'(team_m), rv_m, 3'(last_runs), sr_m, il_m, sf, st};
  endfunction

  function automatic logic [EXP_W-1:0] dut_pack();
    return {bases, outs, bat_team, runs_valid, runs_count, side_retired, illegal_ev,
            score_flat, score_sat};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) occ[b] = 0;
    outs_m = 0; team_m = 0; last_runs = 0;
    for (int t = 0; t < N; t++) begin score_m[t] = 0; sat_m[t] = 0; end
    rv_m = 0; sr_m = 0; il_m = 0;
  endtask

  task automatic add_score(input int r);
    int s;
    rv_m = 1;
    last_runs = r;
    s = score_m[team_m] + r;
    if (s >= SMAX) begin s = SMAX; sat_m[team_m] = 1; end
    score_m[team_m] = s;
  endtask

  // Apply one accepted event to the model and queue the resulting outputs.
  task automatic model_apply(input logic [2:0] code);
    int n, r;
    bit walk_ok;
    rv_m = 0; sr_m = 0; il_m = 0;
`ifdef RUN_TALLY_WALK_EN
    walk_ok = 1;
`else
    walk_ok = 0;
`endif
    if (code == 0) begin
      outs_m++;
      if (outs_m == MOUTS) begin
        outs_m = 0;
        for (int b = 1; b <= 3; b++) occ[b] = 0;
        team_m = (team_m + 1) % N;
        sr_m = 1;
      end
    end else if (code >= 1 && code <= 4) begin
      n = int'(code);
      r = 0;
      for (int b = 3; b >= 1; b--) begin
        if (occ[b]) begin
          occ[b] = 0;
          if (b + n >= 4) r++;
          else occ[b + n] = 1;
        end
      end
      if (n >= 4) r++;
      else occ[n] = 1;
      add_score(r);
    end else if (code == 5 && walk_ok) begin
      r = 0;
      if (occ[1]) begin
        if (occ[2]) begin
          if (occ[3]) r = 1;
          occ[3] = 1;
        end
        occ[2] = 1;
      end
      occ[1] = 1;
      add_score(r);
    end else begin
      il_m = 1;
    end
    exp_q.push_back(model_pack());
  endtask

  // driver tasks: called at posedge+1
  task automatic do_reset();
    reset = 1'b1;
    ev_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    model_reset();
    check("reset_outputs", 64'(dut_pack()), 64'(model_pack()));
    check("reset_ready", 64'(ev_ready), 64'd1);
    check("reset_state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [2:0] code);
    int n = 0;
    while (!ev_ready && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    if (!ev_ready) begin
      check("ready_timeout", 64'(ev_ready), 64'd1);
    end else begin
      ev_valid = 1'b1;
      ev_code = code;
      model_apply(code);
      @(posedge clk);
      #1 ev_valid = 1'b0;
      ev_code = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic hold_singles();
    logic [5:0] pat = 6'b010101;
    int acc = 0;
    int n = 0;
    while (!ev_ready && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    ev_valid = 1'b1;
    ev_code = 3'd1;
    for (int i = 0; i < 6; i++) begin
      check("held_ready_pattern", 64'(ev_ready), 64'(pat[i]));
      if (ev_ready) begin
        model_apply(3'd1);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    ev_valid = 1'b0;
    check("held_accept_count", 64'(acc), 64'd3);
  endtask

  // monitor: a completed event shows as ev_ready returning high
  initial begin
    logic prev_ready = 1'b1;
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ev_ready && !prev_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("event_outputs", 64'(dut_pack()), 64'(e));
          end
        end else begin
          check("idle_pulses", 64'({runs_valid, side_retired, illegal_ev}), 64'd0);
        end
      end
      prev_ready = ev_ready;
    end
  end

  initial begin
    model_reset();
    do_reset();

    // loaded bases, home run
    send(3'd1); send(3'd1); send(3'd1); send(3'd4);

    // double then single from 011
    do_reset();
    send(3'd1); send(3'd1); send(3'd2); send(3'd1);

    // two sides retired, team wraps back to 0
    repeat (3) send(3'd0);
    repeat (3) send(3'd0);

    // saturation at 7 with a 3-bit score
    do_reset();
    repeat (6) send(3'd4);
    send(3'd4);
    send(3'd4);

    // held ev_valid
    hold_singles();

    // code 5 with bases loaded, then reset during APPLY
    do_reset();
    send(3'd1); send(3'd1); send(3'd1);
    send(3'd5);
    send(3'd5);
    do_reset();

    // illegal codes
    send(3'd6); send(3'd7);

    // randomized play
    repeat (300) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      else send(3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
